// File: rtl/relu_pkg.sv
// ---------------------------------------------------------------------------
// relu_pkg
// Shared constants for the streaming activation unit.
//   - Activation mode encodings, used by relu_lane and by anything that
//     drives the mode input of relu_stream.
//   - Default lane width, lane count and leaky shift.
// ---------------------------------------------------------------------------
package relu_pkg;

  // Activation mode encodings carried on the 2-bit mode input
  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_RELU   = 2'd1;
  localparam logic [1:0] MODE_LEAKY  = 2'd2;
  localparam logic [1:0] MODE_CLIP   = 2'd3;

  // Default geometry of the datapath
  localparam int DEFAULT_DATA_W     = 12;
  localparam int DEFAULT_CH         = 4;
  localparam int DEFAULT_LEAK_SHIFT = 3;

endpackage

// File: rtl/relu_lane.sv
// ---------------------------------------------------------------------------
// relu_lane
// Purely combinational single-lane activation. No width growth: the result
// is the same signed width as the input.
// Ports:
//   x_i     in  DATA_W  signed lane value
//   mode_i  in  2       activation mode (see relu_pkg)
//   clip_i  in  DATA_W  signed upper clip level, only used in clip mode
//   y_o     out DATA_W  signed activated value
// ---------------------------------------------------------------------------
module relu_lane
  import relu_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int LEAK_SHIFT = DEFAULT_LEAK_SHIFT
) (
  input  logic signed [DATA_W-1:0] x_i,
  input  logic        [1:0]        mode_i,
  input  logic signed [DATA_W-1:0] clip_i,
  output logic signed [DATA_W-1:0] y_o
);

  logic xNeg;
  logic clipNeg;

  assign xNeg    = x_i[DATA_W-1];
  assign clipNeg = clip_i[DATA_W-1];

  // Select the activation for this lane. The leaky shift is arithmetic, so
  // negative values round toward minus infinity (-210 >>> 3 = -27). A
  // negative clip level forces every value to zero in clip mode, because
  // the lower bound of zero then lies above the upper bound.
  always_comb begin
    y_o = x_i;
    case (mode_i)
      MODE_BYPASS: y_o = x_i;
      MODE_RELU:   y_o = xNeg ? '0 : x_i;
      MODE_LEAKY:  y_o = xNeg ? (x_i >>> LEAK_SHIFT) : x_i;
      MODE_CLIP: begin
        if (xNeg || clipNeg) begin
          y_o = '0;
        end else if (x_i > clip_i) begin
          y_o = clip_i;
        end else begin
          y_o = x_i;
        end
      end
      default:     y_o = x_i;
    endcase
  end

endmodule

// File: rtl/relu_stream.sv
// ---------------------------------------------------------------------------
// relu_stream
// Multi-channel streaming activation unit with a two-stage valid/ready
// pipeline (s1 holds the raw beat, s2 holds the activated beat).
// Ports:
//   clk       in  1          rising-edge clock
//   rst_n     in  1          asynchronous active-low reset
//   mode      in  2          activation mode, captured with each input beat
//   clip_val  in  DATA_W     signed clip level, captured with each input beat
//   s_valid   in  1          input beat valid
//   s_ready   out 1          unit can accept an input beat
//   s_data    in  CH*DATA_W  input lanes, lane i at [i*DATA_W +: DATA_W]
//   m_valid   out 1          output beat valid
//   m_ready   in  1          downstream accepts the output beat
//   m_data    out CH*DATA_W  output lanes, same packing as s_data
// Optional (macro RELU_STATS_EN):
//   stats_clr in  1          clear the negative-lane counter
//   neg_cnt   out 32         saturating count of negative input lanes
// ---------------------------------------------------------------------------
module relu_stream
  import relu_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int CH         = DEFAULT_CH,
  parameter int LEAK_SHIFT = DEFAULT_LEAK_SHIFT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  input  logic [DATA_W-1:0]    clip_val,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [CH*DATA_W-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [CH*DATA_W-1:0] m_data
`ifdef RELU_STATS_EN
  ,
  input  logic                 stats_clr,
  output logic [31:0]          neg_cnt
`endif
);

  logic                 v1_q, v1_d;
  logic [CH*DATA_W-1:0] data1_q, data1_d;
  logic [1:0]           mode1_q, mode1_d;
  logic [DATA_W-1:0]    clip1_q, clip1_d;

  logic                 v2_q, v2_d;
  logic [CH*DATA_W-1:0] data2_q, data2_d;

  logic [CH*DATA_W-1:0] actData;
  logic                 adv1;
  logic                 load1;

  // Handshake. s1 moves on whenever s2 is free or is being drained this
  // cycle; s1 can take a new beat when it is empty or moving on. Written out
  // this gives s_ready = !v1 | !v2 | m_ready, which depends only on state and
  // m_ready and never on s_valid.
  always_comb begin
    adv1    = v1_q & (~v2_q | m_ready);
    s_ready = ~v1_q | adv1;
    load1   = s_valid & s_ready;
  end

  // One activation lane per channel between s1 and s2. Mode and clip level
  // come from s1, so a beat keeps the mode it was accepted with.
  for (genvar g = 0; g < CH; g++) begin : g_lane
    relu_lane #(
      .DATA_W    (DATA_W),
      .LEAK_SHIFT(LEAK_SHIFT)
    ) u_lane (
      .x_i   (data1_q[g*DATA_W +: DATA_W]),
      .mode_i(mode1_q),
      .clip_i(clip1_q),
      .y_o   (actData[g*DATA_W +: DATA_W])
    );
  end

  // Next state of both stages. When s2 is draining and s1 advances in the
  // same cycle, the load wins so m_valid stays high with the new beat.
  // Data registers only change on a load, which keeps m_data stable while
  // the downstream stalls.
  always_comb begin
    v1_d    = v1_q;
    data1_d = data1_q;
    mode1_d = mode1_q;
    clip1_d = clip1_q;
    v2_d    = v2_q;
    data2_d = data2_q;

    if (load1) begin
      v1_d    = 1'b1;
      data1_d = s_data;
      mode1_d = mode;
      clip1_d = clip_val;
    end else if (adv1) begin
      v1_d = 1'b0;
    end

    if (adv1) begin
      v2_d    = 1'b1;
      data2_d = actData;
    end else if (m_ready) begin
      v2_d = 1'b0;
    end
  end

  // Pipeline registers. The asynchronous reset discards everything in
  // flight and clears the output bus as well as the valid flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      data1_q <= '0;
      mode1_q <= MODE_BYPASS;
      clip1_q <= '0;
      v2_q    <= 1'b0;
      data2_q <= '0;
    end else begin
      v1_q    <= v1_d;
      data1_q <= data1_d;
      mode1_q <= mode1_d;
      clip1_q <= clip1_d;
      v2_q    <= v2_d;
      data2_q <= data2_d;
    end
  end

  assign m_valid = v2_q;
  assign m_data  = data2_q;

`ifdef RELU_STATS_EN
  localparam int NEG_W = $clog2(CH + 1);

  logic [NEG_W-1:0] negLanes;
  logic [32:0]      cntSum;
  logic [31:0]      cnt_q, cnt_d;

  // Count the lanes of the incoming beat whose sign bit is set. This looks
  // at the raw input, not the activated output.
  always_comb begin
    negLanes = '0;
    for (int i = 0; i < CH; i++) begin
      negLanes = negLanes + NEG_W'(s_data[i*DATA_W + DATA_W - 1]);
    end
  end

  // Saturating accumulate on each accepted beat. The extra sum bit flags
  // overflow; a clear takes priority over a same-cycle increment.
  always_comb begin
    cntSum = {1'b0, cnt_q} + 33'(negLanes);
    cnt_d  = cnt_q;
    if (stats_clr) begin
      cnt_d = '0;
    end else if (load1) begin
      cnt_d = cntSum[32] ? '1 : cntSum[31:0];
    end
  end

  // Counter register, cleared by the same reset as the datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign neg_cnt = cnt_q;
`endif

endmodule

// File: doc/relu_stream.md
Name: relu_stream

Overview:
- Parametrised, multi-channel streaming activation unit; successor to the single-lane 12-bit ReLU.
- Sits between a convolution/accumulator output and the pooling/next-layer input buffer.
- Applies one of four activation modes to CH signed lanes per beat.
- Two-stage pipeline with valid/ready handshake and full backpressure support.

Parameters:
- DATA_W, 12: width of each signed two's-complement lane.
- CH, 4: number of lanes per beat.
- LEAK_SHIFT, 3: arithmetic right shift applied to negative values in leaky mode. Legal range 1..DATA_W-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  2  activation mode, sampled with each accepted input beat.
- clip_val  in  DATA_W  signed upper clip level for mode 3, sampled with each accepted beat.
- s_valid  in  1  input beat valid.
- s_ready  out  1  unit can accept an input beat.
- s_data  in  CH*DATA_W  input lanes; lane i = bits [i*DATA_W +: DATA_W].
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accepts the output beat.
- m_data  out  CH*DATA_W  output lanes, same packing as s_data.

Behaviour:
- Reset (async assert, sync release): both stage valid flags = 0, m_valid = 0, m_data = 0, s_ready = 1 on the first cycle after release.
- Transfers:
  - Input transfer on s_valid & s_ready at a rising clk edge.
  - Output transfer on m_valid & m_ready at a rising clk edge.
- Stage 1 (register s1): captures s_data, mode and clip_val on an input transfer.
- Stage 2 (register s2): captures the per-lane activation of s1. m_valid/m_data come directly from s2.
- Stage advance rules:
  - s2 loads when s1 is valid and (s2 is empty or m_ready).
  - s1 loads when s_valid and (s1 is empty or s1 advances that cycle).
  - s_ready = !v1 | !v2 | m_ready. This is combinational from m_ready; there is no path from s_valid to s_ready.
- Latency: 2 cycles from input transfer to m_valid with m_ready held at 1. Throughput: 1 beat/cycle.
- Backpressure:
  - While m_valid & !m_ready, m_data is held stable.
  - Both stages fill; s_ready drops to 0 once v1 & v2 & !m_ready.
  - No beat is lost or duplicated.
- Simultaneous output transfer and s1 advance in the same cycle: s2 takes the new data and m_valid stays 1.
- Mode per lane, with x = signed lane value:
  - 0 bypass: y = x.
  - 1 ReLU: y = (x < 0) ? 0 : x.
  - 2 leaky: y = (x < 0) ? x >>> LEAK_SHIFT : x. Floor rounding, e.g. -210 gives -27.
  - 3 clipped ReLU: y = (x < 0) ? 0 : min(x, clip_val). If clip_val < 0, y = 0.
- Arithmetic: no width growth; output is DATA_W signed. The most negative input (0x800 at 12 bit) has no special case.
- Lanes are independent; mode and clip_val apply to all lanes of a beat.
- Mode changes take effect on the next accepted beat only; beats already in flight keep their captured mode.
- Reset mid-stream: all in-flight beats are discarded, valids clear immediately, m_valid = 0 asynchronously.

Optional Feature:
- Macro RELU_STATS_EN.
- Defined:
  - Adds input stats_clr (1 bit) and output neg_cnt (32 bits).
  - neg_cnt increments by the number of negative lanes in each input transfer, sampled from s_data.
  - neg_cnt saturates at 0xFFFFFFFF.
  - stats_clr = 1 zeroes the counter on the next edge; clear wins over a same-cycle increment.
  - neg_cnt resets to 0 on rst_n.
- Undefined: ports and counter are absent; datapath behaviour is identical.

Decomposition:
- Package relu_pkg:
  - Mode localparams MODE_BYPASS=2'd0, MODE_RELU=2'd1, MODE_LEAKY=2'd2, MODE_CLIP=2'd3.
  - Default DATA_W and LEAK_SHIFT constants.
- Sub-module relu_lane: purely combinational single-lane activation (x, mode, clip_val to y), instantiated CH times via generate between s1 and s2.
- Handshake and registers stay in relu_stream.

Test Plan:
- DATA_W=12, mode=1, m_ready=1, beats lane0 = 0x0F1, 0xF2E, 0x555, 0x8AD -> outputs 0x0F1, 0x000, 0x555, 0x000, each 2 cycles after acceptance, one per cycle.
- mode=2, LEAK_SHIFT=3, lane0 0xF2E, 0x8AD, 0x0F1 -> 0xFE5, 0xF15, 0x0F1.
- mode=3, clip_val=0x100, lanes {0x555, 0x0F1, 0xF2E, 0x100} -> {0x100, 0x0F1, 0x000, 0x100}; clip_val=0xFF0 with 0x555 -> 0x000.
- Stream of 10 beats with m_ready toggled 1,0,0,1,... -> s_ready low when both stages are full, m_data stable while stalled, all 10 beats received in order.
- Assert rst_n low with 2 beats in flight -> m_valid = 0 immediately, m_data = 0, no stale beat after release.
- RELU_STATS_EN: 3 beats of 4 lanes with 2 negative lanes each -> neg_cnt = 6; pulse stats_clr in the same cycle as a 4th beat -> neg_cnt = 0.
